kim_bus_arbiter: RTL and testbench

Shares the KIM-1 system bus between the 6502 and a host debug/load port so RAM, ROM and RIOT registers can be read or written while the CPU runs. It sits between the CPU bus pins and the memory/peripheral decode. It stalls the CPU through RDY only on a CPU read cycle, performs one host access, then restores the CPU's address so the stalled read completes correctly. Host transfers use a strobe/ready/ack handshake, and an optional hold keeps the CPU stalled across back-to-back host accesses.

---
 rtl/kim_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_kim_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/kim_bus_arbiter.sv
// KIM-1 bus arbiter: lets a host debug/load port borrow the system bus by stalling
// the 6502 through RDY on a read cycle, then re-presenting the CPU address.
module kim_bus_arbiter #(
   parameter int HOLD_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_AB,
   input  logic [7:0]  cpu_DO,
   input  logic        cpu_WE,
   output logic        cpu_RDY,
   output logic [15:0] mem_AB,
   output logic [7:0]  mem_DO,
   output logic        mem_WE,
   input  logic [7:0]  mem_DI,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [15:0] host_addr,
   input  logic [7:0]  host_wdata,
   input  logic        host_hold,
   output logic        host_ready,
   output logic        host_ack,
   output logic [7:0]  host_rdata,
   output logic        host_busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      ACCESS = 3'd2,
      DONE   = 3'd3,
      CHECK  = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        pending;
   logic        req_we;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic [15:0] holdcnt;
   logic        accept;
   logic        hold_expired;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign accept       = host_req && !pending;
   assign host_ready   = !pending;
   assign hold_expired = (HOLD_TIMEOUT != 0) && (holdcnt == 16'(HOLD_TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset)               pending <= 1'b0;
      else if (state == DONE)  pending <= 1'b0;
      else if (accept)         pending <= 1'b1;
   end

   // Request payload is plain data; pending alone qualifies it.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_we    <= host_we;
         req_addr  <= host_addr;
         req_wdata <= host_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         host_ack   <= 1'b0;
         host_rdata <= 8'h00;
      end else begin
         host_ack <= (state == DONE);
         if (state == DONE && !req_we) host_rdata <= mem_DI;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                                    holdcnt <= 16'd0;
      else if (state != CHECK && state_nxt == CHECK) holdcnt <= 16'd0;
      else if (state == CHECK && state_nxt == CHECK) holdcnt <= sat_inc16(holdcnt);
   end

   // A strobe accepted in CHECK under hold goes straight to ACCESS so
   // back-to-back transfers keep a 3-cycle spacing.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pending) state_nxt = ARM;
         ARM:     if (!cpu_WE) state_nxt = ACCESS;
         ACCESS:  state_nxt = DONE;
         DONE:    state_nxt = CHECK;
         CHECK: begin
            if (pending || (accept && host_hold))  state_nxt = ACCESS;
            else if (host_hold && !hold_expired)   state_nxt = CHECK;
            else                                   state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cpu_RDY   = 1'b1;
      host_busy = 1'b0;
      mem_AB    = cpu_AB;
      mem_DO    = cpu_DO;
      mem_WE    = cpu_WE;
      case (state)
         ARM: begin
            cpu_RDY   = cpu_WE;
            host_busy = !cpu_WE;
         end
         ACCESS: begin
            cpu_RDY   = 1'b0;
            host_busy = 1'b1;
            mem_AB    = req_addr;
            mem_DO    = req_wdata;
            mem_WE    = req_we;
         end
         DONE, CHECK: begin
            cpu_RDY   = 1'b0;
            host_busy = 1'b1;
            mem_WE    = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_kim_bus_arbiter.sv
// Directed bench for kim_bus_arbiter with a registered 64 KiB memory model.
module tb_kim_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_AB;
   logic [7:0]  cpu_DO;
   logic        cpu_WE;
   logic        cpu_RDY;
   logic [15:0] mem_AB;
   logic [7:0]  mem_DO;
   logic        mem_WE;
   logic [7:0]  mem_DI;
   logic        host_req;
   logic        host_we;
   logic [15:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_hold;
   logic        host_ready;
   logic        host_ack;
   logic [7:0]  host_rdata;
   logic        host_busy;

   logic        pre_we;
   logic [15:0] pre_addr;
   logic [7:0]  pre_data;
   logic [7:0]  ram [0:65535];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst;
      logic [15:0] cab;
      logic        cwe;
      logic [7:0]  cdo;
      logic        hreq;
      logic        hwe;
      logic [15:0] haddr;
      logic [7:0]  hwd;
      logic        hold;
      logic        chk;
      logic        rdy;
      logic        hrdy;
      logic        ack;
      logic        busy;
      logic [15:0] mab;
      logic        mwe;
      logic [7:0]  mdo;
      logic [7:0]  rdata;
   } vec_t;

   vec_t       vt [0:19];
   logic [7:0] exp_rd [0:3];

   kim_bus_arbiter #(.HOLD_TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_AB(cpu_AB), .cpu_DO(cpu_DO), .cpu_WE(cpu_WE), .cpu_RDY(cpu_RDY),
      .mem_AB(mem_AB), .mem_DO(mem_DO), .mem_WE(mem_WE), .mem_DI(mem_DI),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_hold(host_hold), .host_ready(host_ready),
      .host_ack(host_ack), .host_rdata(host_rdata), .host_busy(host_busy)
   );

   always #5 clk = ~clk;

   // Registered memory: read data appears one cycle after the address.
   always @(posedge clk) begin
      if (pre_we)      ram[pre_addr] <= pre_data;
      else if (mem_WE) ram[mem_AB]   <= mem_DO;
      mem_DI <= ram[mem_AB];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      reset = 1'b0; cpu_AB = 16'h0200; cpu_WE = 1'b0; cpu_DO = 8'h00;
      host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0000; host_wdata = 8'h00;
      host_hold = 1'b0;
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
   endtask

   initial begin
      vt[0]  = '{1'b1,16'h0200,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,8'h00,8'h00};
      vt[1]  = '{1'b1,16'h0200,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b1,1'b1,1'b0,1'b0,16'h0200,1'b0,8'h00,8'h00};
      vt[2]  = '{1'b0,16'h0200,1'b0,8'h00, 1'b1,1'b0,16'h0010,8'h00,1'b0, 1'b1, 1'b1,1'b1,1'b0,1'b0,16'h0200,1'b0,8'h00,8'h00};
      vt[3]  = '{1'b0,16'h0200,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b0,1'b0,16'h0200,1'b0,8'h00,8'h00};
      vt[4]  = '{1'b0,16'h0200,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,1'b1,16'h0200,1'b0,8'h00,8'h00};
      vt[5]  = '{1'b0,16'h0200,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,1'b1,16'h0010,1'b0,8'h00,8'h00};
      vt[6]  = '{1'b0,16'h0200,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,1'b1,16'h0200,1'b0,8'h00,8'h00};
      vt[7]  = '{1'b0,16'h0200,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b0,1'b1,1'b1,1'b1,16'h0200,1'b0,8'h00,8'h5A};
      vt[8]  = '{1'b0,16'h0200,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b1,1'b1,1'b0,1'b0,16'h0200,1'b0,8'h00,8'h5A};
      vt[9]  = '{1'b0,16'h0200,1'b0,8'h00, 1'b1,1'b1,16'h03FF,8'hA5,1'b0, 1'b1, 1'b1,1'b1,1'b0,1'b0,16'h0200,1'b0,8'h00,8'h5A};
      vt[10] = '{1'b0,16'h0200,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b0,1'b0,16'h0200,1'b0,8'h00,8'h5A};
      vt[11] = '{1'b0,16'h01FF,1'b1,8'h02, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b0,1'b0,16'h01FF,1'b1,8'h02,8'h5A};
      vt[12] = '{1'b0,16'h01FE,1'b1,8'h03, 1'b1,1'b0,16'h0010,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b0,1'b0,16'h01FE,1'b1,8'h03,8'h5A};
      vt[13] = '{1'b0,16'h01FD,1'b1,8'h04, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b1,1'b0,1'b0,1'b0,16'h01FD,1'b1,8'h04,8'h5A};
      vt[14] = '{1'b0,16'hFFFE,1'b0,8'h04, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,1'b1,16'hFFFE,1'b0,8'h04,8'h5A};
      vt[15] = '{1'b0,16'hFFFE,1'b0,8'h04, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,1'b1,16'h03FF,1'b1,8'hA5,8'h5A};
      vt[16] = '{1'b0,16'hFFFE,1'b0,8'h04, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b0,1'b0,1'b0,1'b1,16'hFFFE,1'b0,8'h04,8'h5A};
      vt[17] = '{1'b0,16'hFFFE,1'b0,8'h04, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b0,1'b1,1'b1,1'b1,16'hFFFE,1'b0,8'h04,8'h5A};
      vt[18] = '{1'b0,16'h03FF,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b1,1'b1,1'b0,1'b0,16'h03FF,1'b0,8'h00,8'h5A};
      vt[19] = '{1'b0,16'h0200,1'b0,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0, 1'b1, 1'b1,1'b1,1'b0,1'b0,16'h0200,1'b0,8'h00,8'h5A};
      exp_rd[0] = 8'h5A; exp_rd[1] = 8'h11; exp_rd[2] = 8'h22; exp_rd[3] = 8'h33;

      idle_inputs();
      reset = 1'b1;
      pre_we = 1'b0; pre_addr = 16'h0000; pre_data = 8'h00;
      preload(16'h0010, 8'h5A);
      preload(16'h0011, 8'h11);
      preload(16'h0012, 8'h22);
      preload(16'h0013, 8'h33);
      preload(16'h0200, 8'hEA);
      preload(16'h03FF, 8'h00);
      preload(16'h0300, 8'h00);
      preload(16'h0301, 8'h00);
      @(negedge clk);
      pre_we = 1'b0;

      // Table: isolated host read, then host write behind a 3-write push.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         reset = vt[i].rst; cpu_AB = vt[i].cab; cpu_WE = vt[i].cwe; cpu_DO = vt[i].cdo;
         host_req = vt[i].hreq; host_we = vt[i].hwe; host_addr = vt[i].haddr;
         host_wdata = vt[i].hwd; host_hold = vt[i].hold;
         #1;
         if (vt[i].chk) begin
            chk($sformatf("v%0d_rdy", i),   32'(cpu_RDY),    32'(vt[i].rdy));
            chk($sformatf("v%0d_ready", i), 32'(host_ready), 32'(vt[i].hrdy));
            chk($sformatf("v%0d_ack", i),   32'(host_ack),   32'(vt[i].ack));
            chk($sformatf("v%0d_busy", i),  32'(host_busy),  32'(vt[i].busy));
            chk($sformatf("v%0d_mab", i),   32'(mem_AB),     32'(vt[i].mab));
            chk($sformatf("v%0d_mwe", i),   32'(mem_WE),     32'(vt[i].mwe));
            chk($sformatf("v%0d_mdo", i),   32'(mem_DO),     32'(vt[i].mdo));
            chk($sformatf("v%0d_rdata", i), 32'(host_rdata), 32'(vt[i].rdata));
         end
      end
      chk("cpu_read_03ff", 32'(mem_DI), 32'h0A5);
      chk("ram_03ff",  32'(ram[16'h03FF]), 32'h0A5);
      chk("stack_01ff", 32'(ram[16'h01FF]), 32'h02);
      chk("stack_01fe", 32'(ram[16'h01FE]), 32'h03);
      chk("stack_01fd", 32'(ram[16'h01FD]), 32'h04);

      // Hold: four reads, each new strobe issued in the previous ack cycle.
      for (int c = 0; c < 20; c++) begin
         int k;
         @(negedge clk);
         idle_inputs();
         k = (c == 0) ? 0 : (c == 5) ? 1 : (c == 8) ? 2 : 3;
         host_hold = (c < 18);
         host_req  = (c == 0 || c == 5 || c == 8 || c == 11);
         host_addr = 16'h0010 + 16'(k);
         #1;
         chk($sformatf("hold_rdy_c%0d", c), 32'(cpu_RDY), (c >= 2 && c <= 18) ? 32'd0 : 32'd1);
         chk($sformatf("hold_ack_c%0d", c), 32'(host_ack),
             (c == 5 || c == 8 || c == 11 || c == 14) ? 32'd1 : 32'd0);
         if (c == 5 || c == 8 || c == 11 || c == 14)
            chk($sformatf("hold_rdata_c%0d", c), 32'(host_rdata), 32'(exp_rd[(c - 5) / 3]));
      end

      // Hold timeout: CHECK entered at c=5, forced release after 9 CHECK cycles.
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         idle_inputs();
         host_hold = (c < 16);
         host_req  = (c == 0);
         host_addr = 16'h0012;
         #1;
         chk($sformatf("tmo_rdy_c%0d", c), 32'(cpu_RDY), (c >= 2 && c <= 13) ? 32'd0 : 32'd1);
         if (c == 5) chk("tmo_rdata", 32'(host_rdata), 32'h22);
      end

      // Reset together with a strobe while ready: the strobe is dropped.
      @(negedge clk); idle_inputs();
      reset = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0300; host_wdata = 8'h77;
      for (int c = 1; c < 5; c++) begin
         @(negedge clk); idle_inputs(); #1;
         chk($sformatf("rstreq_ready_c%0d", c), 32'(host_ready), 32'd1);
         chk($sformatf("rstreq_rdy_c%0d", c),   32'(cpu_RDY),    32'd1);
      end

      // Reset during ARM: the write never reaches memory.
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); idle_inputs();
         host_req = (c == 0); host_we = 1'b1; host_addr = 16'h0300; host_wdata = 8'h77;
         reset = (c == 2);
         #1;
         if (c == 2) chk("rst_arm_stalled", 32'(cpu_RDY), 32'd0);
         if (c >= 3) begin
            chk($sformatf("rst_arm_rdy_c%0d", c),   32'(cpu_RDY),    32'd1);
            chk($sformatf("rst_arm_ready_c%0d", c), 32'(host_ready), 32'd1);
            chk($sformatf("rst_arm_ack_c%0d", c),   32'(host_ack),   32'd0);
         end
      end
      chk("rst_arm_ram", 32'(ram[16'h0300]), 32'h00);

      // Reset during ACCESS: the ACCESS edge already wrote the byte.
      for (int c = 0; c < 7; c++) begin
         @(negedge clk); idle_inputs();
         host_req = (c == 0); host_we = 1'b1; host_addr = 16'h0301; host_wdata = 8'h66;
         reset = (c == 3);
         #1;
         if (c == 3) chk("rst_acc_mwe", 32'(mem_WE), 32'd1);
         if (c >= 4) begin
            chk($sformatf("rst_acc_rdy_c%0d", c),   32'(cpu_RDY),    32'd1);
            chk($sformatf("rst_acc_ready_c%0d", c), 32'(host_ready), 32'd1);
            chk($sformatf("rst_acc_ack_c%0d", c),   32'(host_ack),   32'd0);
         end
      end
      chk("rst_acc_ram", 32'(ram[16'h0301]), 32'h66);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
